// File: rtl/frame_read_arbiter_pkg.sv
// Shared definitions for the frame-buffer read arbiter and related ICE arbiters.
//   FRAME_W     : width of one frame-buffer word (bit 8 is the end-of-frame marker)
//   DEF_ADDR_W  : default frame-buffer address width
//   arb_state_e : arbiter FSM encoding, also exported on the debug port
package frame_read_arbiter_pkg;

  localparam int FRAME_W    = 9;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/frame_read_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i     : request vector
//   ptr_i     : highest-priority position this round
//   win_o     : one-hot winner (zero when no request)
//   win_idx_o : binary index of the winner
//   valid_o   : at least one request present
// The first set request at or after ptr_i wins, wrapping past N-1 back to 0.
module frame_read_arbiter_rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] win_idx_o,
  output logic          valid_o
);

  int pos;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      // Wrap by compare so non-power-of-two N works.
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      for (int j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == pos)) begin
          valid_o   = 1'b1;
          win_o[j]  = 1'b1;
          win_idx_o = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/frame_read_arbiter.sv
// Shares the single read port of the host-to-ICE frame buffer among NUM_REQ
// frame consumers, round-robin, one frame per grant.
//   clk, rst_n        : clock, asynchronous active-low reset
//   buf_frame_valid   : buffer holds a complete frame at its current tail
//   buf_rd_data       : buffer read data, fanned out on cons_rd_data
//   buf_rd_addr       : granted consumer's read address (0 when nobody granted)
//   buf_latch_tail    : granted consumer's tail-latch pulse, forwarded same cycle
//   req               : per-consumer level request
//   cons_rd_addr      : packed per-consumer addresses, consumer i at [i*ADDR_W +: ADDR_W]
//   cons_latch_tail   : per-consumer tail-latch pulses
//   gnt               : registered one-hot grant, zero when idle
//   cons_frame_valid  : buf_frame_valid routed to the grantee while in GRANT
//   cons_rd_data      : buf_rd_data, unregistered
//   timeout_err       : sticky, a grant was forcibly released by the watchdog
//   timeout_clr       : clears timeout_err (a simultaneous set wins)
//   state_dbg         : current FSM state
//
// Handshake: req[i] is a level the consumer holds while it wants the buffer;
// consumer i owns the read port exactly while gnt[i] is high. Ownership ends on
// the clock edge where the grantee pulses cons_latch_tail (frame consumed),
// drops req, or the watchdog expires; gnt then drops for a RELEASE cycle so the
// buffer tail and frame_valid settle before anyone else is granted.
module frame_read_arbiter
  import frame_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      buf_frame_valid,
  input  logic [FRAME_W-1:0]        buf_rd_data,
  output logic [ADDR_W-1:0]         buf_rd_addr,
  output logic                      buf_latch_tail,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] cons_rd_addr,
  input  logic [NUM_REQ-1:0]        cons_latch_tail,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        cons_frame_valid,
  output logic [FRAME_W-1:0]        cons_rd_data,
  output logic                      timeout_err,
  input  logic                      timeout_clr,
  output arb_state_e                state_dbg
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [WD_W-1:0]      wd_cnt_q;
  logic                 timeout_err_q;

  logic [NUM_REQ-1:0]   pick_win;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic                 in_grant;
  logic                 sel_latch;
  logic                 sel_req;
  logic                 exit_latch;
  logic                 exit_drop;
  logic                 exit_wd;

  frame_read_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // gnt_q is non-zero only in GRANT, so the mux naturally yields address 0
  // and no latch while idle or releasing.
  always_comb begin
    buf_rd_addr = '0;
    sel_latch   = 1'b0;
    sel_req     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        buf_rd_addr = cons_rd_addr[i*ADDR_W +: ADDR_W];
        sel_latch   = cons_latch_tail[i];
        sel_req     = req[i];
      end
    end
  end

  assign in_grant   = (state_q == ST_GRANT);
  assign exit_latch = in_grant & sel_latch;
  assign exit_drop  = in_grant & ~sel_req;
  assign exit_wd    = in_grant & (wd_cnt_q == WD_LAST);

  assign buf_latch_tail   = exit_latch;
  assign cons_frame_valid = gnt_q & {NUM_REQ{buf_frame_valid & in_grant}};
  assign cons_rd_data     = buf_rd_data;
  assign gnt              = gnt_q;
  assign timeout_err      = timeout_err_q;
  assign state_dbg        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // A watchdog release later in this block overrides the clear.
      if (timeout_clr) timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_win;
            gidx_q  <= pick_idx;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (exit_latch || exit_drop || exit_wd) begin
            gnt_q   <= '0;
            state_q <= ST_RELEASE;
          end
          // Only a genuine watchdog eviction is an error; a latch or a
          // dropped request in the same cycle takes precedence.
          if (exit_wd && !exit_latch && !exit_drop) timeout_err_q <= 1'b1;
        end
        ST_RELEASE: begin
          rr_ptr_q <= (gidx_q == PTR_LAST) ? '0 : gidx_q + 1'b1;
          wd_cnt_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_read_arbiter.sv
module tb_frame_read_arbiter;
  import frame_read_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int TO = 16;
  localparam int W  = 16;
  localparam int K_LATCH = 0;
  localparam int K_DROP  = 1;
  localparam int K_TO    = 2;
  localparam int K_BOTH  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              buf_frame_valid;
  logic [8:0]        buf_rd_data;
  logic [AW-1:0]     buf_rd_addr;
  logic              buf_latch_tail;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   cons_rd_addr;
  logic [N-1:0]      cons_latch_tail;
  logic [N-1:0]      gnt;
  logic [N-1:0]      cons_frame_valid;
  logic [8:0]        cons_rd_data;
  logic              timeout_err;
  logic              timeout_clr;
  arb_state_e        state_dbg;
  logic [AW-1:0]     addr_a [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) cons_rd_addr[i*AW +: AW] = addr_a[i];
  end

  frame_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .buf_frame_valid  (buf_frame_valid),
    .buf_rd_data      (buf_rd_data),
    .buf_rd_addr      (buf_rd_addr),
    .buf_latch_tail   (buf_latch_tail),
    .req              (req),
    .cons_rd_addr     (cons_rd_addr),
    .cons_latch_tail  (cons_latch_tail),
    .gnt              (gnt),
    .cons_frame_valid (cons_frame_valid),
    .cons_rd_data     (cons_rd_data),
    .timeout_err      (timeout_err),
    .timeout_clr      (timeout_clr),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  // Expected grant record: [3:0] one-hot grantee, [4] tail latch forwarded,
  // [5] watchdog eviction, [15:8] grant length in cycles.
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;
  bit mon_en = 1'b0;
  bit chk_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (model_ptr + i) % N;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    buf_frame_valid = 1'($urandom_range(0, 1));
    buf_rd_data     = 9'($urandom);
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) addr_a[i] = AW'($urandom);
  endtask

  task automatic run_txn(input logic [N-1:0] mask, input int kind, input int k,
                         input int exp_lat, input bit clr_at_end);
    int w, lat, n, len;
    logic [W-1:0] e;
    logic [N-1:0] oh, noise;
    w  = model_pick(mask);
    oh = N'(1 << w);
    len = (kind == K_TO) ? TO : k;
    e = '0;
    e[3:0]  = oh;
    e[4]    = (kind == K_LATCH) || (kind == K_BOTH);
    e[5]    = (kind == K_TO);
    e[15:8] = 8'(len);
    exp_q.push_back(e);
    model_ptr = (w + 1) % N;
    chk_gap = (exp_lat == 2);
    req = mask;
    timeout_clr = 1'b1;
    cons_latch_tail = '0;
    lat = 0;
    do begin
      step();
      timeout_clr = 1'b0;
      lat++;
    end while (gnt == '0 && lat < 8);
    if (gnt == '0) begin
      chk("grant_arrived", 32'(gnt != '0), 1);
      req = '0;
      return;
    end
    if (exp_lat != 0) chk("grant_latency", lat, exp_lat);
    for (int c = 1; c <= len; c++) begin
      noise = N'($urandom) & ~oh;
      cons_latch_tail = noise;
      if (c == k && (kind == K_LATCH || kind == K_BOTH)) cons_latch_tail = noise | oh;
      if (c == k && (kind == K_DROP || kind == K_BOTH)) req = req & ~oh;
      if (kind == K_TO && c == TO && clr_at_end) timeout_clr = 1'b1;
      step();
      timeout_clr = 1'b0;
    end
    cons_latch_tail = '0;
    n = 0;
    while (gnt != '0 && n < 40) begin
      step();
      n++;
    end
    chk("grant_released", gnt, 0);
  endtask

  // ---------------- monitor ----------------
  bit           in_g = 1'b0;
  bit           seen_end = 1'b0;
  int           len_m, pulses, gap, cw;
  logic [W-1:0] cur;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      in_g = 1'b0;
      seen_end = 1'b0;
    end else if (gnt != '0) begin
      if (!in_g) begin
        if (chk_gap && seen_end) chk("idle_gap", gap, 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", gnt, 0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        in_g = 1'b1;
        len_m = 0;
        pulses = 0;
        cw = 0;
        for (int i = 0; i < N; i++) if (cur[i]) cw = i;
      end
      len_m++;
      if (buf_latch_tail) pulses++;
      chk("gnt", gnt, cur[3:0]);
      chk("buf_rd_addr", buf_rd_addr, addr_a[cw]);
      chk("cons_frame_valid", cons_frame_valid, buf_frame_valid ? cur[3:0] : 4'b0);
      chk("cons_rd_data", cons_rd_data, buf_rd_data);
    end else begin
      if (in_g) begin
        chk("grant_len", len_m, cur[15:8]);
        chk("latch_pulses", pulses, cur[4]);
        chk("timeout_err", timeout_err, cur[5]);
        in_g = 1'b0;
        seen_end = 1'b1;
        gap = 0;
      end
      gap++;
      chk("idle_latch", buf_latch_tail, 0);
      chk("idle_addr", buf_rd_addr, 0);
      chk("idle_frame_valid", cons_frame_valid, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    rst_n = 1'b0;
    req = 4'b1111;
    cons_latch_tail = 4'b1111;
    timeout_clr = 1'b0;
    buf_frame_valid = 1'b1;
    buf_rd_data = '0;
    rand_addrs();
    #12;
    chk("reset_gnt", gnt, 0);
    chk("reset_latch", buf_latch_tail, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_addr", buf_rd_addr, 0);
    chk("reset_frame_valid", cons_frame_valid, 0);
    chk("reset_state", state_dbg, ST_IDLE);
    req = '0;
    cons_latch_tail = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    mon_en = 1'b1;

    // Single requester 2 from idle, addr 0x05A, latch in first grant cycle.
    rand_addrs();
    addr_a[2] = 9'h05A;
    run_txn(4'b0100, K_LATCH, 1, 1, 1'b0);

    // All request, each latches after 3 cycles; pointer continues after 2.
    for (int i = 0; i < 5; i++) begin
      rand_addrs();
      run_txn(4'b1111, K_LATCH, 3, 2, 1'b0);
    end

    // Grantee 1 drops its request; next grant goes to 2.
    rand_addrs();
    run_txn(4'b0110, K_DROP, 2, 2, 1'b0);
    rand_addrs();
    run_txn(4'b0110, K_LATCH, 2, 2, 1'b0);

    // Watchdog eviction with timeout_clr in the same cycle; flag must hold.
    rand_addrs();
    run_txn(4'b1001, K_TO, TO, 2, 1'b1);
    req = '0;
    step();
    step();
    step();
    chk("timeout_err_held", timeout_err, 1);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    chk("timeout_err_cleared", timeout_err, 0);

    // Long grant of consumer 0 with random latch noise from the others.
    rand_addrs();
    run_txn(4'b0001, K_LATCH, 6, 1, 1'b0);

    // Randomized traffic, including boundary lengths at the watchdog limit.
    for (int i = 0; i < 40; i++) begin
      int kind, k;
      rand_addrs();
      kind = $urandom_range(0, 3);
      k = ($urandom_range(0, 4) == 0) ? TO : $urandom_range(1, 6);
      run_txn(N'($urandom_range(1, 15)), kind, k, 2, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a grant.
    mon_en = 1'b0;
    req = 4'b1100;
    w = model_pick(4'b1100);
    begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (gnt == '0 && n < 8);
    end
    chk("pre_reset_gnt", gnt, N'(1 << w));
    cons_latch_tail = N'(1 << w);
    #2;
    chk("pre_reset_latch", buf_latch_tail, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", gnt, 0);
    chk("async_reset_latch", buf_latch_tail, 0);
    chk("async_reset_addr", buf_rd_addr, 0);
    chk("async_reset_state", state_dbg, ST_IDLE);
    cons_latch_tail = '0;
    req = 4'b1010;
    step();
    step();
    rst_n = 1'b1;
    model_ptr = 0;
    exp_q.delete();
    mon_en = 1'b1;
    rand_addrs();
    run_txn(4'b1010, K_LATCH, 2, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rand_addrs();
      run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 6), 2, 1'b0);
    end

    req = '0;
    step();
    step();
    step();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
